// File: rtl/pkt_stream_fifo.sv
// Store-and-forward packet FIFO with speculative write, commit, rewind and drop.
// Optional feature: define PKT_FIFO_DROP_ERR_EN to discard packets flagged with err on eop.
module pkt_stream_fifo #(
    parameter int DATA_W      = 64,
    parameter int MOD_W       = 3,
    parameter int DEPTH       = 256,
    parameter int FULL_MARGIN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_in_val,
    input  logic              pkt_in_sop,
    input  logic              pkt_in_eop,
    input  logic [MOD_W-1:0]  pkt_in_mod,
    input  logic [DATA_W-1:0] pkt_in_data,
    input  logic              pkt_in_err,
    output logic              pkt_in_full,
    output logic              pkt_out_avail,
    input  logic              pkt_out_ren,
    output logic              pkt_out_val,
    output logic              pkt_out_sop,
    output logic              pkt_out_eop,
    output logic [MOD_W-1:0]  pkt_out_mod,
    output logic [DATA_W-1:0] pkt_out_data,
    output logic              pkt_out_err,
    output logic [15:0]       pkt_drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DATA_W + MOD_W + 3;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] FULL_TH = PW'(DEPTH - FULL_MARGIN);
    localparam logic [PW-1:0] ONE     = PW'(1);

    typedef enum logic [1:0] {IDLE, PKT, DISCARD} wr_state_t;

    logic [EW-1:0] mem [DEPTH];

    wr_state_t     state, state_n;
    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, pkt_cnt;
    logic [PW-1:0] wr_ptr_n, commit_ptr_n, rd_ptr_n, pkt_cnt_n;
    logic [PW-1:0] base, occ_n;
    logic          abort_sop, accept, no_free;
    logic          wr_en, commit, rewind, drop;
    logic          rd_en;
    logic [EW-1:0] wr_word, rd_word;

    assign wr_word = {pkt_in_data, pkt_in_mod, pkt_in_sop, pkt_in_eop,
                      pkt_in_err & pkt_in_eop};

    // A sop inside a packet restarts writing at the last commit point.
    always_comb begin
        abort_sop = (state == PKT) && pkt_in_val && pkt_in_sop;
        base      = abort_sop ? commit_ptr : wr_ptr;
        no_free   = ((base - rd_ptr) == DEPTH_P);
        accept    = pkt_in_val && (pkt_in_sop || (state == PKT));
        wr_en     = 1'b0;
        commit    = 1'b0;
        rewind    = 1'b0;
        drop      = 1'b0;
        state_n   = state;
        if (accept) begin
            if (no_free) begin
                rewind  = 1'b1;
                drop    = 1'b1;
                state_n = DISCARD;
            end else begin
                wr_en = 1'b1;
                drop  = abort_sop;
                if (pkt_in_eop) begin
                    state_n = IDLE;
`ifdef PKT_FIFO_DROP_ERR_EN
                    if (pkt_in_err) begin
                        rewind = 1'b1;
                        drop   = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
`else
                    commit = 1'b1;
`endif
                end else begin
                    state_n = PKT;
                end
            end
        end
    end

    always_comb begin
        wr_ptr_n = wr_ptr;
        if (rewind)
            wr_ptr_n = commit_ptr;
        else if (wr_en)
            wr_ptr_n = base + ONE;
        commit_ptr_n = commit ? base + ONE : commit_ptr;
    end

    assign rd_en    = pkt_out_ren && (rd_ptr != commit_ptr);
    assign rd_word  = mem[rd_ptr[AW-1:0]];
    assign rd_ptr_n = rd_en ? rd_ptr + ONE : rd_ptr;
    assign occ_n    = wr_ptr_n - rd_ptr_n;

    always_comb begin
        pkt_cnt_n = pkt_cnt;
        unique case ({commit, rd_en && rd_word[1]})
            2'b10:   pkt_cnt_n = pkt_cnt + ONE;
            2'b01:   pkt_cnt_n = pkt_cnt - ONE;
            default: pkt_cnt_n = pkt_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[base[AW-1:0]] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            rd_ptr        <= '0;
            pkt_cnt       <= '0;
            pkt_in_full   <= 1'b0;
            pkt_out_avail <= 1'b0;
            pkt_drop_cnt  <= '0;
        end else begin
            state         <= state_n;
            wr_ptr        <= wr_ptr_n;
            commit_ptr    <= commit_ptr_n;
            rd_ptr        <= rd_ptr_n;
            pkt_cnt       <= pkt_cnt_n;
            pkt_in_full   <= (occ_n >= FULL_TH);
            pkt_out_avail <= (pkt_cnt_n != '0);
            pkt_drop_cnt  <= pkt_drop_cnt + 16'(drop);
        end
    end

    // Framing and data hold their last value between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_out_val  <= 1'b0;
            pkt_out_sop  <= 1'b0;
            pkt_out_eop  <= 1'b0;
            pkt_out_mod  <= '0;
            pkt_out_data <= '0;
            pkt_out_err  <= 1'b0;
        end else begin
            pkt_out_val <= rd_en;
            if (rd_en)
                {pkt_out_data, pkt_out_mod, pkt_out_sop,
                 pkt_out_eop, pkt_out_err} <= rd_word;
        end
    end
endmodule

// File: doc/pkt_stream_fifo.md
# pkt_stream_fifo

Parametrised store-and-forward packet FIFO carrying the 10G MAC packet protocol: an input port with the TX-side signalling (val/sop/eop/mod/data, full back-pressure) and an output port with the RX-side signalling (avail/ren/val/sop/eop/mod/data/err). It sits between the MAC RX client port and the TX client port for loopback and switch-fabric buffering. It generalises the fixed 64-bit packet port to any word width and depth, and adds packet commit, rewind and drop behaviour.

## Interface
- DATA_W, 64, data word width in bits; a multiple of 8, at least 16.
- MOD_W, 3, byte-count width; must equal $clog2(DATA_W/8).
- DEPTH, 256, FIFO entries (words); a power of two, at least 8.
- FULL_MARGIN, 4, pkt_in_full asserts when free entries <= FULL_MARGIN; must be less than DEPTH.
- clk  input  1  single clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pkt_in_val  input  1  input word valid.
- pkt_in_sop  input  1  first word of packet.
- pkt_in_eop  input  1  last word of packet.
- pkt_in_mod  input  MOD_W  valid bytes in the eop word; 0 means all bytes valid.
- pkt_in_data  input  DATA_W  input data.
- pkt_in_err  input  1  packet error; sampled only on the eop word.
- pkt_in_full  output  1  back-pressure to the writer.
- pkt_out_avail  output  1  at least one complete packet is committed.
- pkt_out_ren  input  1  read enable.
- pkt_out_val  output  1  output word valid.
- pkt_out_sop, pkt_out_eop  output  1 each  output framing.
- pkt_out_mod  output  MOD_W  output byte count.
- pkt_out_data  output  DATA_W  output data.
- pkt_out_err  output  1  error flag on the eop word.
- pkt_drop_cnt  output  16  count of discarded packets; wraps.

## Operation
- Each entry stores {data, mod, sop, eop, err}.
- Pointers: wr_ptr (speculative), commit_ptr, and rd_ptr, each $clog2(DEPTH)+1 bits and wrapping naturally. The extra MSB distinguishes full from empty.
- Write FSM states:
  - IDLE: sop&val writes the word and moves to PKT. A sop&eop word commits immediately and stays in IDLE. A val without sop is ignored.
  - PKT: val writes the word. eop commits (commit_ptr <= wr_ptr+1) and returns to IDLE.
  - DISCARD: words are ignored until the next sop&val, which is handled as in IDLE.
- Abort cases, each rewinding wr_ptr to commit_ptr and incrementing pkt_drop_cnt:
  - Write with no free entry: the FSM enters DISCARD.
  - sop while in PKT: the partial packet is discarded and the new sop word is written as the start of a new packet.
- pkt_cnt counts committed, unread packets. It increments on commit and decrements when an eop word is read. When both happen in the same cycle, pkt_cnt is unchanged.
- A read occurs when pkt_out_ren=1 and rd_ptr != commit_ptr. Otherwise ren is ignored and pkt_out_val=0 on the following cycle. Reads run freely across packet boundaries.
- The reader never reads uncommitted words.

## Timing
- Reset values: all outputs 0, all pointers 0, pkt_cnt 0, FSM in IDLE. Reset mid-packet or mid-read discards all contents.
- Read latency: pkt_out_* are registered and valid exactly 1 cycle after an accepted ren.
- Between reads, pkt_out_val=0; the data/framing outputs hold their last values.
- pkt_out_avail: registered, equals (pkt_cnt != 0), and rises the cycle after the eop word is written.
- pkt_in_full: registered from the next-cycle occupancy (wr_ptr - rd_ptr). This includes same-cycle writes and reads, so the writer may issue up to FULL_MARGIN words after full asserts without loss.

## Configuration
- PKT_FIFO_DROP_ERR_EN defined:
  - An eop word with pkt_in_err=1 rewinds wr_ptr to commit_ptr instead of committing.
  - pkt_drop_cnt increments, and the packet never reaches the output.
- PKT_FIFO_DROP_ERR_EN undefined:
  - The packet commits normally and is delivered with pkt_out_err=1 on its eop word.

## Test plan
- 3-word packet, eop mod=5 -> avail=1 one cycle after eop. ren held 3 cycles -> val on cycles +1..+3, sop on first, eop&mod=5 on third. avail=0 after the eop read.
- DEPTH=16, FULL_MARGIN=4, no reads, 12-word packet -> full=1 the cycle after word 12. A further 20-word packet -> drop_cnt=1, avail still reflects only the first packet, and the 12 words read back intact.
- Error packet (2 words, err on eop) -> with the macro: avail stays 0, drop_cnt=1. Without the macro: read back with pkt_out_err=1 on word 2.
- Packet A, 2 words without eop, then packet B sop+3 words -> drop_cnt=1. Only B is read, with sop on its first word.
- pkt_cnt=1; the final eop read and a new commit in the same cycle -> avail stays 1 and the second packet reads correctly.
- reset asserted during a read with 2 packets stored -> next cycle: avail=0, val=0, full=0, drop_cnt=0. A fresh packet then round-trips correctly.
